// File: rtl/lenet_pkg.sv
// Shared constants, FSM encoding and buffer routing for the LeNet-5 layer sequencer.
package lenet_pkg;

  localparam int NUM_LAYERS = 7;

  localparam logic [2:0] L_CONV1 = 3'd0;
  localparam logic [2:0] L_POOL1 = 3'd1;
  localparam logic [2:0] L_CONV2 = 3'd2;
  localparam logic [2:0] L_POOL2 = 3'd3;
  localparam logic [2:0] L_FC1   = 3'd4;
  localparam logic [2:0] L_FC2   = 3'd5;
  localparam logic [2:0] L_FC3   = 3'(NUM_LAYERS - 1);

  localparam logic [1:0] BUF_A   = 2'd0;
  localparam logic [1:0] BUF_B   = 2'd1;
  localparam logic [1:0] BUF_C   = 2'd2;
  localparam logic [1:0] BUF_IMG = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_NEXT,
    ST_FINISH
  } state_e;

  typedef struct packed {
    logic [1:0] src;
    logic [1:0] dst;
  } route_t;

  // Layers ping-pong between A and B; the classifier output lands in C.
  function automatic logic [1:0] dst_of(input logic [2:0] k);
    if (k == L_FC3) return BUF_C;
    return k[0] ? BUF_B : BUF_A;
  endfunction

  function automatic route_t route(input logic [2:0] k);
    route_t r;
    r.src = (k == L_CONV1) ? BUF_IMG : dst_of(k - 3'd1);
    r.dst = dst_of(k);
    return r;
  endfunction

endpackage

// File: rtl/lenet_watchdog.sv
// Per-layer watchdog: loads a fixed budget, counts down while enabled, flags zero.
module lenet_watchdog #(
  parameter int LOAD_VALUE = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LOAD_VALUE + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(LOAD_VALUE);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/lenet_layer_sequencer.sv
// LeNet-5 layer scheduler: launches each engine in turn, routes the ping-pong
// buffers, guards every layer with a watchdog and records inference latency.
module lenet_layer_sequencer
  import lenet_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  infer_start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic [1:0]            src_sel,
  output logic [1:0]            dst_sel,
  output logic [2:0]            cur_layer,
  output logic                  busy,
  output logic                  infer_done,
  output logic                  timeout_err,
  output logic [31:0]           cycle_count
);

  // state  | meaning
  // IDLE   | waiting for infer_start
  // LAUNCH | start pulse out for cur_layer, watchdog armed
  // WAIT   | engine running, watchdog counting down
  // NEXT   | layer finished, advance or finish
  // FINISH | infer_done pulse, latency captured

  state_e                state_q, state_d;
  logic [2:0]            cur_layer_q, cur_layer_d;
  logic [1:0]            src_sel_q, src_sel_d;
  logic [1:0]            dst_sel_q, dst_sel_d;
  logic [NUM_LAYERS-1:0] layer_start_q, layer_start_d;
  logic                  busy_q, busy_d;
  logic                  infer_done_q, infer_done_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [31:0]           cycle_count_q, cycle_count_d;
  logic [31:0]           run_cnt_q, run_cnt_d;
  logic                  cur_done;
  logic                  enter_launch;
  logic                  wd_en;
  logic                  wd_expired;
  route_t                rt;

  assign cur_done = layer_done[cur_layer_q];

  always_comb begin
    state_d       = state_q;
    cur_layer_d   = cur_layer_q;
    timeout_err_d = timeout_err_q;
    cycle_count_d = cycle_count_q;
    run_cnt_d     = (state_q == ST_IDLE) ? run_cnt_q : run_cnt_q + 32'd1;

    case (state_q)
      ST_IDLE: begin
        if (infer_start) begin
          state_d       = ST_LAUNCH;
          cur_layer_d   = L_CONV1;
          timeout_err_d = 1'b0;
          run_cnt_d     = '0;
        end
      end
      ST_LAUNCH: state_d = cur_done ? ST_NEXT : ST_WAIT;
      ST_WAIT: begin
        if (wd_expired) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (cur_done) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (cur_layer_q == L_FC3) begin
          state_d = ST_FINISH;
        end else begin
          cur_layer_d = cur_layer_q + 3'd1;
          state_d     = ST_LAUNCH;
        end
      end
      ST_FINISH: begin
        cycle_count_d = run_cnt_q + 32'd1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything and leaves the reported results untouched.
    if (abort) begin
      state_d       = ST_IDLE;
      cur_layer_d   = cur_layer_q;
      timeout_err_d = timeout_err_q;
      cycle_count_d = cycle_count_q;
    end
  end

  // Routing and start pulse are registered on entry to LAUNCH only.
  always_comb begin
    enter_launch  = (state_d == ST_LAUNCH);
    rt            = route(cur_layer_d);
    src_sel_d     = enter_launch ? rt.src : src_sel_q;
    dst_sel_d     = enter_launch ? rt.dst : dst_sel_q;
    layer_start_d = enter_launch ? (NUM_LAYERS'(1) << cur_layer_d) : '0;
    busy_d        = (state_d != ST_IDLE);
    infer_done_d  = (state_d == ST_FINISH);
    wd_en         = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
  end

  lenet_watchdog #(
    .LOAD_VALUE(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .load   (enter_launch),
    .en     (wd_en),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cur_layer_q   <= L_CONV1;
      src_sel_q     <= BUF_IMG;
      dst_sel_q     <= BUF_A;
      layer_start_q <= '0;
      busy_q        <= 1'b0;
      infer_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      cycle_count_q <= '0;
      run_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cur_layer_q   <= cur_layer_d;
      src_sel_q     <= src_sel_d;
      dst_sel_q     <= dst_sel_d;
      layer_start_q <= layer_start_d;
      busy_q        <= busy_d;
      infer_done_q  <= infer_done_d;
      timeout_err_q <= timeout_err_d;
      cycle_count_q <= cycle_count_d;
      run_cnt_q     <= run_cnt_d;
    end
  end

  assign layer_start = layer_start_q;
  assign src_sel     = src_sel_q;
  assign dst_sel     = dst_sel_q;
  assign cur_layer   = cur_layer_q;
  assign busy        = busy_q;
  assign infer_done  = infer_done_q;
  assign timeout_err = timeout_err_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: doc/lenet_layer_sequencer.md
# lenet_layer_sequencer

Top-level scheduler for the LeNet-5 inference core. It launches the seven layer engines (conv1, pool1, conv2, pool2, fc1, fc2, fc3) one at a time with start/done pulses. It drives the buffer-routing selects so each layer reads the previous layer's output and writes the alternate buffer. It also guards every layer with a watchdog and reports total inference latency.

## Interface
- NUM_LAYERS, 7, number of layer engines sequenced; index 0 = conv1, index NUM_LAYERS-1 = fc3.
- TIMEOUT_CYCLES, 200000, maximum cycles allowed between a layer's start and its done.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- infer_start  in  1  single-cycle request to begin one inference.
- abort  in  1  terminate the current inference immediately.
- layer_done  in  NUM_LAYERS  per-engine done pulse.
- layer_start  out  NUM_LAYERS  one-hot, single-cycle engine start.
- src_sel  out  2  read-buffer select.
- dst_sel  out  2  write-buffer select.
- cur_layer  out  3  index of the layer currently launched or running.
- busy  out  1  high from the cycle after an accepted infer_start through the FINISH cycle.
- infer_done  out  1  single-cycle pulse when the last layer completes.
- timeout_err  out  1  sticky watchdog flag; cleared by the next accepted infer_start or by rst.
- cycle_count  out  32  latency of the last successful inference, in cycles.

## Operation
- Buffer encoding: BUF_A=0, BUF_B=1, BUF_C=2, BUF_IMG=3.
- Routing for layer k:
  - src = BUF_IMG if k=0, else dst of layer k-1.
  - dst = BUF_C if k=NUM_LAYERS-1, BUF_A if k is even, BUF_B if k is odd.
- FSM states: IDLE, LAUNCH, WAIT, NEXT, FINISH.
- IDLE:
  - On infer_start: cur_layer←0, load src/dst for layer 0, clear timeout_err, clear the running counter, go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH (one cycle):
  - layer_start[cur_layer]=1; watchdog←TIMEOUT_CYCLES.
  - If layer_done[cur_layer] is high in this cycle, go to NEXT; otherwise go to WAIT.
- WAIT:
  - Watchdog decrements every cycle.
  - layer_done[cur_layer] → NEXT.
  - layer_done bits for any other layer are ignored.
  - Watchdog at 0 with no done → timeout_err←1, go to IDLE; no infer_done.
- NEXT:
  - If cur_layer=NUM_LAYERS-1 → FINISH.
  - Otherwise cur_layer+1, load that layer's src/dst, go to LAUNCH.
- FINISH: infer_done=1, cycle_count←running counter, go to IDLE.
- src_sel, dst_sel and cur_layer update only when a LAUNCH is entered. They hold stable through WAIT and after completion.
- The running counter increments in every non-IDLE cycle. It counts the first LAUNCH through FINISH inclusive.
- infer_start while not in IDLE is ignored.
- abort:
  - From any state, go to IDLE on the next edge; layer_start is zeroed.
  - No infer_done pulse; cycle_count and timeout_err are unchanged.
  - Priority: abort > timeout > done.
- abort together with infer_start in IDLE: abort wins and the FSM stays in IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - layer_start=0, infer_done=0, busy=0, timeout_err=0.
  - cycle_count=0, cur_layer=0.
  - src_sel=BUF_IMG, dst_sel=BUF_A.
  - State = IDLE.
- rst asserted mid-inference forces these reset values on the next edge.
- infer_start sampled at edge N → layer_start[0] high during cycle N+1.
- layer_done[k] sampled at edge M → NEXT during cycle M+1 → layer_start[k+1] high during cycle M+2 (inter-layer gap of 2 cycles).
- Last layer_done at edge M → infer_done high during cycle M+2; busy falls in cycle M+3.
- With every engine done exactly D cycles after its start pulse, cycle_count = NUM_LAYERS·(D+2)+1.
- Timeout: with no done, timeout_err rises TIMEOUT_CYCLES+1 cycles after layer_start; busy falls in the same cycle.

## Structure
- lenet_pkg holds:
  - the buffer encodings BUF_A, BUF_B, BUF_C, BUF_IMG;
  - the layer index constants and NUM_LAYERS;
  - the FSM state encoding;
  - the route function (k → src/dst).
- One sub-module, lenet_watchdog: load/decrement/expire counter with load, enable and expired ports, instantiated once.

## Test plan
- Normal run, each engine done 10 cycles after its start:
  - Seven start pulses in order.
  - src/dst sequence = 3/0, 0/1, 1/0, 0/1, 1/0, 0/1, 1/2.
  - Exactly one infer_done; cycle_count=85.
- TIMEOUT_CYCLES=50, pool2 (layer 3) never done:
  - timeout_err=1 at 51 cycles after layer_start[3].
  - busy=0, no infer_done, layer_start[4] never asserted.
- abort asserted during conv2 WAIT:
  - IDLE on the next edge; no further start pulses; infer_done=0.
  - A subsequent infer_start runs a clean inference from layer 0.
- Stray done bits: layer_done[5] pulsed while layer 1 is in WAIT → ignored; sequence unchanged.
- Zero-latency engine: layer_done[2] high in its own LAUNCH cycle → layer_start[3] asserted 2 cycles later.
- Start handling:
  - infer_start re-pulsed while busy → ignored, single infer_done.
  - rst mid-run → all outputs at reset values on the next cycle.
